// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings for the execute stage: icodes, status codes,
// ALU function codes, branch/move condition codes, the condition-code
// register layout and the M pipeline register layout with its bubble value.
package y86_pkg;

  // Instruction codes
  typedef enum logic [3:0] {
    I_HALT   = 4'h0,
    I_NOP    = 4'h1,
    I_RRMOVQ = 4'h2,  // also the conditional moves
    I_IRMOVQ = 4'h3,
    I_RMMOVQ = 4'h4,
    I_MRMOVQ = 4'h5,
    I_OPQ    = 4'h6,
    I_JXX    = 4'h7,
    I_CALL   = 4'h8,
    I_RET    = 4'h9,
    I_PUSHQ  = 4'hA,
    I_POPQ   = 4'hB
  } icode_t;

  // Pipeline status codes
  typedef enum logic [3:0] {
    S_AOK = 4'h1,
    S_HLT = 4'h2,
    S_ADR = 4'h3,
    S_INS = 4'h4
  } stat_t;

  // Register id meaning "no register"
  localparam logic [3:0] RNONE = 4'hF;

  // ALU function codes
  typedef enum logic [1:0] {
    ALU_ADD = 2'd0,
    ALU_SUB = 2'd1,
    ALU_AND = 2'd2,
    ALU_XOR = 2'd3
  } alufn_t;

  // Condition codes carried in ifun of jXX / cmovXX
  typedef enum logic [3:0] {
    C_YES = 4'd0,
    C_LE  = 4'd1,
    C_L   = 4'd2,
    C_E   = 4'd3,
    C_NE  = 4'd4,
    C_GE  = 4'd5,
    C_G   = 4'd6
  } cond_t;

  // Condition-code register
  typedef struct packed {
    logic zf;
    logic sf;
    logic of;
  } cc_t;

  localparam cc_t CC_RESET = '{zf: 1'b1, sf: 1'b0, of: 1'b0};

  // Execute -> memory pipeline register
  typedef struct packed {
    logic [3:0]  stat;
    logic [3:0]  icode;
    logic        cnd;
    logic [63:0] valE;
    logic [63:0] valA;
    logic [3:0]  dstE;
    logic [3:0]  dstM;
  } mreg_t;

  localparam mreg_t M_BUBBLE = '{
    stat:  S_AOK,
    icode: I_NOP,
    cnd:   1'b0,
    valE:  64'd0,
    valA:  64'd0,
    dstE:  RNONE,
    dstM:  RNONE
  };

  // True for the status values that mark an excepting instruction
  function automatic logic is_fault(input logic [3:0] stat);
    return (stat == S_HLT) || (stat == S_ADR) || (stat == S_INS);
  endfunction

  // Evaluate a condition code against a CC snapshot
  function automatic logic cond_eval(input cc_t cc, input logic [3:0] ifun);
    logic lt;
    lt = cc.sf ^ cc.of;
    case (ifun)
      C_YES:   return 1'b1;
      C_LE:    return lt | cc.zf;
      C_L:     return lt;
      C_E:     return cc.zf;
      C_NE:    return ~cc.zf;
      C_GE:    return ~lt;
      C_G:     return ~lt & ~cc.zf;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/execute_pipelining_if.sv
// Signal bundle between the decode/E register, the execute stage and the
// memory stage. master drives the E-register side and observes the results;
// slave is the execute stage itself.
interface execute_pipelining_if;

  // E-register contents
  logic [3:0]  E_stat;
  logic [3:0]  E_icode;
  logic [3:0]  E_ifun;
  logic [63:0] E_valC;
  logic [63:0] E_valA;
  logic [63:0] E_valB;
  logic [3:0]  E_dstE;
  logic [3:0]  E_dstM;

  // Downstream status used to suppress CC updates behind an exception
  logic [3:0]  m_stat;
  logic [3:0]  W_stat;

  // Pipeline control
  logic        M_bubble;

  // Combinational forwarding outputs
  logic [63:0] e_valE;
  logic [3:0]  e_dstE;
  logic        e_cnd;

  // Registered M-stage outputs
  logic [3:0]  M_stat;
  logic [3:0]  M_icode;
  logic        M_cnd;
  logic [63:0] M_valE;
  logic [63:0] M_valA;
  logic [3:0]  M_dstE;
  logic [3:0]  M_dstM;

  modport master (
    output E_stat, E_icode, E_ifun, E_valC, E_valA, E_valB, E_dstE, E_dstM,
    output m_stat, W_stat, M_bubble,
    input  e_valE, e_dstE, e_cnd,
    input  M_stat, M_icode, M_cnd, M_valE, M_valA, M_dstE, M_dstM
  );

  modport slave (
    input  E_stat, E_icode, E_ifun, E_valC, E_valA, E_valB, E_dstE, E_dstM,
    input  m_stat, W_stat, M_bubble,
    output e_valE, e_dstE, e_cnd,
    output M_stat, M_icode, M_cnd, M_valE, M_valA, M_dstE, M_dstM
  );

endinterface

// File: rtl/alu_pipelining.sv
// Combinational 64-bit ALU (add/sub/and/xor) plus ZF/SF/OF generation.
// Zero-cycle latency; no state and no flow control.
// Subtraction computes b - a so that OPq sub yields rB - rA.
module alu_pipelining
  import y86_pkg::*;
(
  input  logic [63:0] alu_a_i,
  input  logic [63:0] alu_b_i,
  input  alufn_t      alu_fn_i,
  output logic [63:0] result_o,
  output cc_t         cc_o
);

  logic [63:0] res;
  logic        of;

  // Compute the result and the signed-overflow flag for the selected operation
  always_comb begin
    res = '0;
    of  = 1'b0;
    case (alu_fn_i)
      ALU_ADD: begin
        res = alu_b_i + alu_a_i;
        of  = (alu_a_i[63] == alu_b_i[63]) && (res[63] != alu_a_i[63]);
      end
      ALU_SUB: begin
        res = alu_b_i - alu_a_i;
        of  = (alu_b_i[63] != alu_a_i[63]) && (res[63] != alu_b_i[63]);
      end
      ALU_AND: res = alu_b_i & alu_a_i;
      ALU_XOR: res = alu_b_i ^ alu_a_i;
      default: begin
        res = '0;
        of  = 1'b0;
      end
    endcase
  end

  assign result_o = res;
  assign cc_o     = '{zf: (res == 64'd0), sf: res[63], of: of};

endmodule

// File: rtl/execute_pipelining.sv
// Y86-64 execute stage: operand select, ALU, CC register, condition
// evaluation and the E->M pipeline register. ALU/forwarding outputs are
// combinational; M outputs appear one clk edge later. M_bubble squashes the load.
module execute_pipelining (
  input  logic                 clk,
  input  logic                 rst,
  execute_pipelining_if.slave  ex
);
  import y86_pkg::*;

  logic [63:0] alu_a;
  logic [63:0] alu_b;
  alufn_t      alu_fn;
  logic [63:0] alu_res;
  cc_t         alu_cc;

  logic        set_cc;
  cc_t         cc_q, cc_d;

  logic        cnd;
  logic [3:0]  dst_e;

  mreg_t       m_q, m_d;

  // Select ALU operand A: register value, constant, or stack-pointer step
  always_comb begin
    alu_a = '0;
    case (ex.E_icode)
      I_RRMOVQ, I_OPQ:            alu_a = ex.E_valA;
      I_IRMOVQ, I_RMMOVQ,
      I_MRMOVQ:                   alu_a = ex.E_valC;
      I_CALL, I_PUSHQ:            alu_a = 64'hFFFF_FFFF_FFFF_FFF8;
      I_RET, I_POPQ:              alu_a = 64'd8;
      default:                    alu_a = '0;
    endcase
  end

  // Select ALU operand B: rB for memory/stack/arith ops, zero for moves
  always_comb begin
    alu_b = '0;
    case (ex.E_icode)
      I_RMMOVQ, I_MRMOVQ, I_OPQ,
      I_CALL, I_RET,
      I_PUSHQ, I_POPQ:            alu_b = ex.E_valB;
      default:                    alu_b = '0;
    endcase
  end

  // Only OPq picks its own ALU operation; everything else computes an address
  // or move value with add. OPq function codes are two bits wide.
  always_comb begin
    alu_fn = ALU_ADD;
    if (ex.E_icode == I_OPQ) begin
      alu_fn = alufn_t'(ex.E_ifun[1:0]);
    end
  end

  alu_pipelining u_alu (
    .alu_a_i  (alu_a),
    .alu_b_i  (alu_b),
    .alu_fn_i (alu_fn),
    .result_o (alu_res),
    .cc_o     (alu_cc)
  );

  // A younger OPq must not update CC once an older instruction has faulted
  assign set_cc = (ex.E_icode == I_OPQ) && !is_fault(ex.m_stat) && !is_fault(ex.W_stat);

  // CC next state: take the fresh flags only when this is a qualifying OPq
  always_comb begin
    cc_d = cc_q;
    if (set_cc) begin
      cc_d = alu_cc;
    end
  end

  // CC register with synchronous reset to ZF=1
  always_ff @(posedge clk) begin
    if (rst) begin
      cc_q <= CC_RESET;
    end else begin
      cc_q <= cc_d;
    end
  end

  // Conditions see the committed CC, never this cycle's flags
  assign cnd = cond_eval(cc_q, ex.E_ifun);

  // A cmov whose condition fails writes no register
  always_comb begin
    dst_e = ex.E_dstE;
    if ((ex.E_icode == I_RRMOVQ) && !cnd) begin
      dst_e = RNONE;
    end
  end

  // M register next state: bubble overrides the normal load
  always_comb begin
    m_d = '{
      stat:  ex.E_stat,
      icode: ex.E_icode,
      cnd:   cnd,
      valE:  alu_res,
      valA:  ex.E_valA,
      dstE:  dst_e,
      dstM:  ex.E_dstM
    };
    if (ex.M_bubble) begin
      m_d = M_BUBBLE;
    end
  end

  // M register; reset loads the bubble and wins over everything else
  always_ff @(posedge clk) begin
    if (rst) begin
      m_q <= M_BUBBLE;
    end else begin
      m_q <= m_d;
    end
  end

  assign ex.e_valE  = alu_res;
  assign ex.e_dstE  = dst_e;
  assign ex.e_cnd   = cnd;

  assign ex.M_stat  = m_q.stat;
  assign ex.M_icode = m_q.icode;
  assign ex.M_cnd   = m_q.cnd;
  assign ex.M_valE  = m_q.valE;
  assign ex.M_valA  = m_q.valA;
  assign ex.M_dstE  = m_q.dstE;
  assign ex.M_dstM  = m_q.dstM;

endmodule

// File: tb/tb_execute_pipelining.sv
// Testbench for execute_pipelining: directed corner cases followed by random
// instructions, all compared against an arithmetic reference model.
module tb_execute_pipelining;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  execute_pipelining_if ifc ();

  execute_pipelining dut (
    .clk (clk),
    .rst (rst),
    .ex  (ifc)
  );

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  // Reference state: CC as {zf,sf,of} and the expected M register
  logic [2:0]  mcc;
  logic [3:0]  x_stat, x_icode, x_dstE, x_dstM;
  logic        x_cnd;
  logic [63:0] x_valE, x_valA;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] ref_a(input logic [3:0] ic, input logic [63:0] va, input logic [63:0] vc);
    case (ic)
      4'h2, 4'h6:       return va;
      4'h3, 4'h4, 4'h5: return vc;
      4'h8, 4'hA:       return -64'sd8;
      4'h9, 4'hB:       return 64'd8;
      default:          return 64'd0;
    endcase
  endfunction

  function automatic logic [63:0] ref_b(input logic [3:0] ic, input logic [63:0] vb);
    if (ic inside {4'h4, 4'h5, 4'h6, 4'h8, 4'h9, 4'hA, 4'hB}) return vb;
    return 64'd0;
  endfunction

  // Result and flags {zf,sf,of}; overflow found from a 65-bit exact sum
  task automatic ref_exec(input logic [3:0] ic, input logic [3:0] fn_in,
                          input logic [63:0] va, input logic [63:0] vb, input logic [63:0] vc,
                          output logic [63:0] res, output logic [2:0] flags);
    logic [63:0] a, b;
    logic [64:0] wide;
    logic [1:0]  fn;
    logic        of;
    a  = ref_a(ic, va, vc);
    b  = ref_b(ic, vb);
    fn = (ic == 4'h6) ? fn_in[1:0] : 2'd0;
    of = 1'b0;
    case (fn)
      2'd0: begin wide = {b[63], b} + {a[63], a}; res = wide[63:0]; of = wide[64] ^ wide[63]; end
      2'd1: begin wide = {b[63], b} - {a[63], a}; res = wide[63:0]; of = wide[64] ^ wide[63]; end
      2'd2: res = a & b;
      default: res = a ^ b;
    endcase
    flags = {res == 64'd0, res[63], of};
  endtask

  function automatic logic ref_cond(input logic [2:0] cc, input logic [3:0] fn);
    logic zf, lt;
    zf = cc[2];
    lt = cc[1] ^ cc[0];
    case (fn)
      4'd0: return 1'b1;
      4'd1: return lt | zf;
      4'd2: return lt;
      4'd3: return zf;
      4'd4: return !zf;
      4'd5: return !lt;
      4'd6: return !lt && !zf;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic bad(input logic [3:0] s);
    return (s >= 4'd2) && (s <= 4'd4);
  endfunction

  // One instruction through the stage: drive at negedge, check the
  // combinational outputs, then check M and CC just after the next posedge.
  task automatic step(input logic [3:0] st, input logic [3:0] ic, input logic [3:0] fn,
                      input logic [63:0] vc, input logic [63:0] va, input logic [63:0] vb,
                      input logic [3:0] de, input logic [3:0] dm,
                      input logic [3:0] ms, input logic [3:0] ws,
                      input logic bub, input logic r, input bit chk_comb, input string tag);
    logic [63:0] res;
    logic [2:0]  flags;
    logic        c;
    logic [3:0]  dste;
    @(negedge clk);
    ifc.E_stat = st;  ifc.E_icode = ic; ifc.E_ifun = fn;
    ifc.E_valC = vc;  ifc.E_valA  = va; ifc.E_valB = vb;
    ifc.E_dstE = de;  ifc.E_dstM  = dm;
    ifc.m_stat = ms;  ifc.W_stat  = ws;
    ifc.M_bubble = bub;
    rst = r;
    #1;
    ref_exec(ic, fn, va, vb, vc, res, flags);
    c    = ref_cond(mcc, fn);
    dste = (ic == 4'h2 && !c) ? 4'hF : de;
    if (chk_comb) begin
      chk({tag, ".e_valE"}, ifc.e_valE, res);
      chk({tag, ".e_cnd"},  64'(ifc.e_cnd), 64'(c));
      chk({tag, ".e_dstE"}, 64'(ifc.e_dstE), 64'(dste));
    end
    if (r || bub) begin
      x_stat = 4'h1; x_icode = 4'h1; x_cnd = 1'b0; x_valE = 64'd0;
      x_valA = 64'd0; x_dstE = 4'hF; x_dstM = 4'hF;
    end else begin
      x_stat = st; x_icode = ic; x_cnd = c; x_valE = res;
      x_valA = va; x_dstE = dste; x_dstM = dm;
    end
    if (r) mcc = 3'b100;
    else if (ic == 4'h6 && !bad(ms) && !bad(ws)) mcc = flags;
    @(posedge clk);
    #1;
    chk({tag, ".M_stat"},  64'(ifc.M_stat),  64'(x_stat));
    chk({tag, ".M_icode"}, 64'(ifc.M_icode), 64'(x_icode));
    chk({tag, ".M_cnd"},   64'(ifc.M_cnd),   64'(x_cnd));
    chk({tag, ".M_valE"},  ifc.M_valE,        x_valE);
    chk({tag, ".M_valA"},  ifc.M_valA,        x_valA);
    chk({tag, ".M_dstE"},  64'(ifc.M_dstE),  64'(x_dstE));
    chk({tag, ".M_dstM"},  64'(ifc.M_dstM),  64'(x_dstM));
    chk({tag, ".cc"},      64'(dut.cc_q),    64'(mcc));
  endtask

  initial begin
    logic [3:0]  ic, fn;
    logic [63:0] va, vb, vc;
    mcc = 3'bxxx;
    rst = 1'b1;

    // Reset state
    step(4'h1, 4'h6, 4'h0, 64'd0, 64'd1, 64'd2, 4'h3, 4'hF, 4'h1, 4'h1, 1'b0, 1'b1, 1'b0, "reset");
    chk("reset_cc", 64'(dut.cc_q), 64'(3'b100));
    chk("reset_M_dstE", 64'(ifc.M_dstE), 64'hF);

    // Add overflow
    step(4'h1, 4'h6, 4'h0, 64'd0, 64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF,
         4'h3, 4'hF, 4'h1, 4'h1, 1'b0, 1'b0, 1'b1, "add_ovf");
    chk("add_ovf_valE", ifc.e_valE, 64'hFFFF_FFFF_FFFF_FFFE);
    chk("add_ovf_cc", 64'(dut.cc_q), 64'(3'b011));

    // Sub to zero, then je / jne against the new CC
    step(4'h1, 4'h6, 4'h1, 64'd0, 64'd5, 64'd5, 4'h3, 4'hF, 4'h1, 4'h1, 1'b0, 1'b0, 1'b1, "sub_zero");
    chk("sub_zero_valE", ifc.e_valE, 64'd0);
    chk("sub_zero_cc", 64'(dut.cc_q), 64'(3'b100));
    step(4'h1, 4'h7, 4'h3, 64'h40, 64'd0, 64'd0, 4'hF, 4'hF, 4'h1, 4'h1, 1'b0, 1'b0, 1'b1, "je");
    chk("je_cnd", 64'(ifc.M_cnd), 64'd1);
    step(4'h1, 4'h7, 4'h4, 64'h40, 64'd0, 64'd0, 4'hF, 4'hF, 4'h1, 4'h1, 1'b0, 1'b0, 1'b1, "jne");
    chk("jne_cnd", 64'(ifc.M_cnd), 64'd0);

    // cmove not taken with ZF=0
    step(4'h1, 4'h6, 4'h0, 64'd0, 64'd1, 64'd1, 4'h3, 4'hF, 4'h1, 4'h1, 1'b0, 1'b0, 1'b1, "set_nz");
    step(4'h1, 4'h2, 4'h3, 64'd0, 64'd77, 64'd0, 4'h2, 4'hF, 4'h1, 4'h1, 1'b0, 1'b0, 1'b1, "cmove");
    chk("cmove_e_cnd", 64'(ifc.e_cnd), 64'd0);
    chk("cmove_e_dstE", 64'(ifc.e_dstE), 64'hF);
    chk("cmove_M_dstE", 64'(ifc.M_dstE), 64'hF);

    // CC gating and stack pointer arithmetic
    step(4'h1, 4'h6, 4'h3, 64'd0, 64'h55, 64'h55, 4'h3, 4'hF, 4'h3, 4'h1, 1'b0, 1'b0, 1'b1, "xor_gated");
    chk("xor_gated_cc", 64'(dut.cc_q), 64'(3'b000));
    step(4'h1, 4'h6, 4'h3, 64'd0, 64'h55, 64'h55, 4'h3, 4'hF, 4'h1, 4'h4, 1'b0, 1'b0, 1'b1, "xor_gated_w");
    chk("xor_gated_w_cc", 64'(dut.cc_q), 64'(3'b000));
    step(4'h1, 4'h8, 4'h0, 64'h200, 64'd0, 64'h100, 4'h4, 4'hF, 4'h1, 4'h1, 1'b0, 1'b0, 1'b1, "call");
    chk("call_valE", ifc.M_valE, 64'hF8);
    step(4'h1, 4'hB, 4'h0, 64'd0, 64'd0, 64'h100, 4'h4, 4'h5, 4'h1, 4'h1, 1'b0, 1'b0, 1'b1, "popq");
    chk("popq_valE", ifc.M_valE, 64'h108);

    // Control priority
    step(4'h1, 4'h5, 4'h0, 64'h10, 64'd0, 64'h300, 4'hF, 4'h4, 4'h1, 4'h1, 1'b1, 1'b0, 1'b1, "bubble");
    chk("bubble_icode", 64'(ifc.M_icode), 64'd1);
    chk("bubble_dstM", 64'(ifc.M_dstM), 64'hF);
    step(4'h1, 4'h6, 4'h1, 64'd0, 64'd9, 64'd3, 4'h3, 4'hF, 4'h1, 4'h1, 1'b1, 1'b1, 1'b1, "rst_bubble");
    chk("rst_bubble_cc", 64'(dut.cc_q), 64'(3'b100));

    // Random instructions, including unknown icodes, faults, bubbles, resets
    for (int i = 0; i < 300; i++) begin
      ic = 4'($urandom_range(0, 15));
      fn = (ic == 4'h6) ? 4'($urandom_range(0, 3)) : 4'($urandom_range(0, 7));
      case ($urandom_range(0, 3))
        0:       begin va = 64'($urandom_range(0, 3)); vb = 64'($urandom_range(0, 3)); end
        1:       begin va = {1'b0, 63'h7FFF_FFFF_FFFF_FFF0} + 64'($urandom_range(0, 31));
                       vb = {$urandom, $urandom}; end
        default: begin va = {$urandom, $urandom}; vb = {$urandom, $urandom}; end
      endcase
      vc = {$urandom, $urandom};
      step(4'($urandom_range(1, 4)), ic, fn, vc, va, vb,
           4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
           4'($urandom_range(0, 4)), 4'($urandom_range(0, 4)),
           ($urandom_range(0, 7) == 0), ($urandom_range(0, 19) == 0), 1'b1, "rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
